// File: rtl/uzorak_punjac_pkg.sv
// Shared constants for the sonar sample assembler and the neuron layer:
// frame geometry, assembler FSM encoding and feature slot offsets.
package uzorak_punjac_pkg;

   localparam int BROJ_ZNACAJKI = 60;
   localparam int SIRINA        = 16;
   localparam int UZORAK_W      = BROJ_ZNACAJKI * SIRINA;
   localparam int KAZ_W         = 6;
   localparam int POMAK_W       = 10;

   typedef enum logic [1:0] {
      PUNJENJE = 2'd0,
      PUN      = 2'd1,
      ODBACI   = 2'd2
   } stanje_t;

   // Bit offset of feature slot k inside the packed sample.
   function automatic logic [POMAK_W-1:0] pomak(input logic [KAZ_W-1:0] k);
      return POMAK_W'(k) * POMAK_W'(SIRINA);
   endfunction

endpackage

// File: rtl/uzorak_punjac.sv
// Packs 60 sign-magnitude features into one 960-bit sample, checks frame
// length and double-buffers so the next frame fills while one is held.
module uzorak_punjac
   import uzorak_punjac_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   input  logic [SIRINA-1:0]   in_data,
   input  logic                in_last,
   output logic                in_ready,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [UZORAK_W-1:0] uzorak,
   output logic                greska,
   output logic [15:0]         broj_okvira
);

   localparam logic [KAZ_W-1:0] ZADNJI = KAZ_W'(BROJ_ZNACAJKI - 1);

   stanje_t             stanje, stanje_nxt;
   logic [KAZ_W-1:0]    kaz, kaz_nxt;
   logic [UZORAK_W-1:0] fill;
   logic [UZORAK_W-1:0] uzorak_q;
   logic                out_valid_q, out_valid_nxt;
   logic                greska_q, greska_nxt;
   logic [15:0]         broj_q;
   logic                prihvat, hs, izlaz_slob;
   logic                ucitaj_otkucaj, ucitaj_fill, ucitaj;

   assign in_ready    = (stanje != PUN);
   assign prihvat     = in_valid && in_ready;
   assign hs          = out_valid_q && out_ready;
   assign izlaz_slob  = !out_valid_q || out_ready;
   assign ucitaj      = ucitaj_otkucaj || ucitaj_fill;

   assign out_valid   = out_valid_q;
   assign uzorak      = uzorak_q;
   assign greska      = greska_q;
   assign broj_okvira = broj_q;

   always_comb begin
      stanje_nxt     = stanje;
      kaz_nxt        = kaz;
      greska_nxt     = 1'b0;
      ucitaj_otkucaj = 1'b0;
      ucitaj_fill    = 1'b0;
      unique case (stanje)
         PUNJENJE: begin
            if (prihvat) begin
               if (kaz < ZADNJI) begin
                  if (in_last) begin
                     greska_nxt = 1'b1;
                     kaz_nxt    = '0;
                  end else begin
                     kaz_nxt = kaz + 1'b1;
                  end
               end else begin
                  kaz_nxt = '0;
                  if (!in_last) begin
                     greska_nxt = 1'b1;
                     stanje_nxt = ODBACI;
                  end else if (izlaz_slob) begin
                     ucitaj_otkucaj = 1'b1;
                  end else begin
                     stanje_nxt = PUN;
                  end
               end
            end
         end
         PUN: begin
            if (hs) begin
               ucitaj_fill = 1'b1;
               stanje_nxt  = PUNJENJE;
            end
         end
         ODBACI: begin
            if (prihvat && in_last) stanje_nxt = PUNJENJE;
         end
         default: stanje_nxt = PUNJENJE;
      endcase
   end

   always_comb begin
      out_valid_nxt = out_valid_q;
      if (ucitaj)  out_valid_nxt = 1'b1;
      else if (hs) out_valid_nxt = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stanje      <= PUNJENJE;
         kaz         <= '0;
         out_valid_q <= 1'b0;
         greska_q    <= 1'b0;
         broj_q      <= '0;
         uzorak_q    <= '0;
      end else begin
         stanje      <= stanje_nxt;
         kaz         <= kaz_nxt;
         out_valid_q <= out_valid_nxt;
         greska_q    <= greska_nxt;
         if (ucitaj) broj_q <= broj_q + 16'd1;
         // The final beat bypasses the fill register so the sample is ready one cycle after it.
         if (ucitaj_otkucaj)   uzorak_q <= {in_data, fill[UZORAK_W-SIRINA-1:0]};
         else if (ucitaj_fill) uzorak_q <= fill;
      end
   end

   // Fill slots carry data only; they are overwritten, never cleared.
   always_ff @(posedge clk) begin
      if (prihvat && (stanje == PUNJENJE)) fill[pomak(kaz) +: SIRINA] <= in_data;
   end

endmodule
